mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 4:1 single-bit mux (selects s1/s0, inputs a/b/c/d).
- Shares the one mux output among four requesters.
- Drives the select lines, issues one-hot grants, limits tenure to MAX_HOLD cycles while others wait, and presents a registered, qualified copy of the selected bit.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles for one requester while another is pending. Legal range 1..7.
- CNT_W, 3: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit0 = mux input a, bit3 = d.
- din  input  4  data bit per requester (din[0]=a .. din[3]=d).
- gnt  output  4  one-hot grant, registered.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered.
- y_q  output  1  registered mux output, qualified by y_vld.
- y_vld  output  1  y_q holds the granted requester's data.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (async, rst_n low): state=IDLE, gnt=4'b0000, {s1,s0}=2'b00, y_q=0, y_vld=0, busy=0, last-grant pointer=3 (requester 0 wins first), hold counter=0. All outputs take these values immediately and hold them while rst_n is low.
- Selection: winner = first asserted req scanning upward (mod 4) from pointer+1.
- IDLE:
  - req==0: stay, outputs unchanged, except gnt=0 and y_vld=0. Selects keep their last value.
  - req!=0: next edge -> GRANT. gnt=onehot(winner), {s1,s0}=winner index, pointer=winner, counter=1, busy=1.
- GRANT, each edge, with cur = pointer:
  - req[cur]=0 and another req pending: switch directly to the new winner, with no idle bubble. Counter=1.
  - req[cur]=0 and no other req: -> IDLE. gnt=0, busy=0, y_vld=0. Selects hold.
  - req[cur]=1, counter==MAX_HOLD, another req pending: rotate to the next winner. Counter=1.
  - req[cur]=1, otherwise: keep grant. Counter increments, saturating at MAX_HOLD.
  - Consequence: with no contention, tenure is unlimited.
- Latency:
  - req to gnt/sel: 1 cycle.
  - y_q: registered din[{s1,s0}] using the already-registered selects, so y_q follows gnt by 1 further cycle.
  - y_vld = gnt!=0 delayed 1 cycle, i.e. 2 cycles after the first req.
- Simultaneous events:
  - All four requesting: grant order 0,1,2,3,0..., with MAX_HOLD cycles each.
  - A requester dropping in the same cycle another rises: handled by the rotation rule.
- A grant never changes mid-cycle, and gnt is always one-hot or zero.
- Reset mid-grant: immediate return to reset values. Pointer reinitialises to 3.

Optional Feature:
- Macro: MUX4_ARB_PRIO0_EN.
- Defined: requester 0 is high priority. In IDLE, or at any arbitration point (drop or hold expiry), req[0]=1 wins regardless of the pointer. Requester 0 is exempt from MAX_HOLD. Its grant ends only when req[0] drops; the remaining requesters then rotate round-robin.
- Undefined: pure round-robin as described above, with no extra logic.

Test Plan:
- Reset: rst_n=0 mid-run with req=4'b1111 -> same cycle gnt=0, {s1,s0}=00, y_vld=0, y_q=0. Release, then req=4'b0100 -> next edge gnt=0100, {s1,s0}=10. One edge later y_q=din[2], y_vld=1.
- Rotation: req=4'b1111 held, din=4'b0101 -> gnt 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, back to 0001. y_q sequence 1,0,1,0 with one-cycle lag.
- No-contention hold: req=4'b0010 for 20 cycles -> gnt=0010 throughout, {s1,s0}=01, busy=1, no rotation.
- Drop and handover: grant on 0, req=4'b1001, then req becomes 4'b1000 -> next edge gnt=1000, {s1,s0}=11, no gnt=0 cycle. Then req=0 -> gnt=0, busy=0, {s1,s0} stays 11, y_vld falls one cycle later.
- Pointer fairness: grant on 2 ends, then req=4'b1011 -> winner 3, then 0, then 1.
- MUX4_ARB_PRIO0_EN defined: grant on 1, req=4'b0011 -> at hold expiry gnt=0001. Requester 0 holds past MAX_HOLD until req[0]=0, then gnt=0010.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 4:1 mux: select lines, one-hot grants, hold limit, registered output bit.
// Optional build macro MUX4_ARB_PRIO0_EN makes requester 0 a high-priority requester that is exempt from the hold limit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant outstanding; gnt=0 and the selects keep their last value
// GRANT | one requester owns the mux; the hold counter tracks its tenure

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       y_q,
    output logic       y_vld,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       sel;
    logic [1:0]       sel_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [1:0]       rr_idx;
    logic             rr_found;
    logic [1:0]       scan;
    logic [1:0]       win_idx;
    logic [3:0]       win_onehot;
    logic [3:0]       cur_mask;
    logic             others;
    logic             hold_exp;

    // Round-robin search starting just above the last granted requester;
    // the current owner is visited last, so it only wins when alone.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        scan     = ptr;
        for (int i = 1; i <= 4; i++) begin
            scan = ptr + 2'(i);
            if (!rr_found && req[scan]) begin
                rr_found = 1'b1;
                rr_idx   = scan;
            end
        end
    end

`ifdef MUX4_ARB_PRIO0_EN
    always_comb begin
        win_idx = req[0] ? 2'd0 : rr_idx;
    end
    // Requester 0 never runs out of tenure.
    assign hold_exp = (cnt == CNT_MAX) && (ptr != 2'd0);
`else
    always_comb begin
        win_idx = rr_idx;
    end
    assign hold_exp = (cnt == CNT_MAX);
`endif

    assign win_onehot = 4'b0001 << win_idx;
    assign cur_mask   = 4'b0001 << ptr;
    assign others     = |(req & ~cur_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            ptr   <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                if (|req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = win_onehot;
                    sel_nxt   = win_idx;
                    ptr_nxt   = win_idx;
                    cnt_nxt   = CNT_ONE;
                end
            end
            GRANT: begin
                if (!req[ptr]) begin
                    if (others) begin
                        // Direct handover, no idle bubble between owners.
                        gnt_nxt = win_onehot;
                        sel_nxt = win_idx;
                        ptr_nxt = win_idx;
                        cnt_nxt = CNT_ONE;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        cnt_nxt   = '0;
                    end
                end else if (hold_exp && others) begin
                    gnt_nxt = win_onehot;
                    sel_nxt = win_idx;
                    ptr_nxt = win_idx;
                    cnt_nxt = CNT_ONE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // Output stage samples the mux through the already-registered selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= 1'b0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= |gnt;
            if (|gnt) begin
                y_q <= din[sel];
            end
        end
    end

    assign s1   = sel[1];
    assign s0   = sel[0];
    assign busy = (state == GRANT);

endmodule
